// File: rtl/regfile_mp.sv
// Register file with two read ports, two write ports and a per-register busy scoreboard.
// After reset, an init sweep clears one entry per cycle. Define REGFILE_BYPASS_EN to forward writes to same-cycle reads.
module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            rs1_en,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,

    input  logic            rs2_en,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,

    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,

    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,

    input  logic            busy_set_en,
    input  logic [AW-1:0]   busy_set_addr,

    output logic            ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   sweep_cnt_reg, sweep_cnt_next;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy_reg, busy_next;

    // One-hot per-entry strobes
    logic [NREG-1:0] sweep_hit;
    logic [NREG-1:0] wr0_hit;
    logic [NREG-1:0] wr1_hit;
    logic [NREG-1:0] set_hit;
    logic            run;

    assign run   = (state_reg == ST_RUN);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (sweep_cnt_reg == AW'(NREG - 1)) begin
                    state_next     = ST_RUN;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Entry 0 is never a write target, so it only ever holds the sweep's zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        assign sweep_hit[gi] = !run && (sweep_cnt_reg == AW'(gi));
        if (gi == 0) begin : g_zero
            assign wr0_hit[gi] = 1'b0;
            assign wr1_hit[gi] = 1'b0;
            assign set_hit[gi] = 1'b0;
        end else begin : g_nonzero
            assign wr0_hit[gi] = run && wr0_en      && (wr0_addr      == AW'(gi));
            assign wr1_hit[gi] = run && wr1_en      && (wr1_addr      == AW'(gi));
            assign set_hit[gi] = run && busy_set_en && (busy_set_addr == AW'(gi));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (sweep_hit[i]) begin
                mem[i] <= '0;
            end else if (wr1_hit[i]) begin
                mem[i] <= wr1_data;
            end else if (wr0_hit[i]) begin
                mem[i] <= wr0_data;
            end
        end
    end

    // A new producer's set overrides the completing write's clear.
    assign busy_next = (busy_reg & ~(wr0_hit | wr1_hit)) | set_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    logic [1:0]      rd_en;
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic [1:0]      rd_busy;

    assign rd_en      = {rs2_en, rs1_en};
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rs1_data   = rd_data[0];
    assign rs2_data   = rd_data[1];
    assign rs1_busy   = rd_busy[0];
    assign rs2_busy   = rd_busy[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        always_comb begin
            rd_data[gi] = '0;
            rd_busy[gi] = 1'b0;
            if (run && rd_en[gi] && (rd_addr[gi] != '0)) begin
                rd_data[gi] = mem[rd_addr[gi]];
                rd_busy[gi] = busy_reg[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                if (wr1_en && (wr1_addr == rd_addr[gi])) begin
                    rd_data[gi] = wr1_data;
                    rd_busy[gi] = busy_set_en && (busy_set_addr == rd_addr[gi]);
                end else if (wr0_en && (wr0_addr == rd_addr[gi])) begin
                    rd_data[gi] = wr0_data;
                    rd_busy[gi] = busy_set_en && (busy_set_addr == rd_addr[gi]);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NREG=32, XLEN=64); honours REGFILE_BYPASS_EN if defined.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            rs1_en, rs2_en;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            wr0_en, wr1_en;
    logic [AW-1:0]   wr0_addr, wr1_addr;
    logic [XLEN-1:0] wr0_data, wr1_data;
    logic            busy_set_en;
    logic [AW-1:0]   busy_set_addr;
    logic            ready;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_en        (rs1_en),
        .rs1_addr      (rs1_addr),
        .rs1_data      (rs1_data),
        .rs1_busy      (rs1_busy),
        .rs2_en        (rs2_en),
        .rs2_addr      (rs2_addr),
        .rs2_data      (rs2_data),
        .rs2_busy      (rs2_busy),
        .wr0_en        (wr0_en),
        .wr0_addr      (wr0_addr),
        .wr0_data      (wr0_data),
        .wr1_en        (wr1_en),
        .wr1_addr      (wr1_addr),
        .wr1_data      (wr1_data),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
    endtask

    task automatic test_reset();
        logic exp_ready;
        rst = 1'b1;
        rs1_en = 1'b1; rs1_addr = 5'd5;
        rs2_en = 1'b1; rs2_addr = 5'd9;
        idle();
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: ready=%b expected 0", ready);
        end
        rst = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            tick();
            exp_ready = (k == NREG - 1);
            checks++;
            if (ready !== exp_ready) begin
                errors++; $display("FAIL sweep_ready[%0d]: ready=%b expected %b", k, ready, exp_ready);
            end
            if (k == 10) begin
                checks++;
                if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
                    errors++; $display("FAIL init_read: data=%h busy=%b expected 0/0", rs1_data, rs1_busy);
                end
            end
        end
        for (int a = 0; a < NREG; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(NREG - 1 - a);
            #1;
            checks++;
            if (rs1_data !== '0 || rs2_data !== '0) begin
                errors++; $display("FAIL post_init_zero[%0d]: rs1=%h rs2=%h expected 0", a, rs1_data, rs2_data);
            end
        end
        $display("reset: sweep complete, ready=%b", ready);
    endtask

    task automatic test_dual_write();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h1111;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 64'h2222;
        tick();
        idle();
        rs1_en = 1'b1; rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 64'h2222) begin
            errors++; $display("FAIL dual_same_addr: rs1_data=%h expected 2222", rs1_data);
        end
        $display("dual write x5: read %h", rs1_data);
        wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 64'h66;
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 64'h88;
        tick();
        idle();
        rs1_addr = 5'd6; rs2_en = 1'b1; rs2_addr = 5'd8;
        #1;
        checks++;
        if (rs1_data !== 64'h66 || rs2_data !== 64'h88) begin
            errors++; $display("FAIL dual_diff_addr: rs1=%h rs2=%h expected 66/88", rs1_data, rs2_data);
        end
        $display("dual write x6/x8: read %h/%h", rs1_data, rs2_data);
    endtask

    task automatic test_x0();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 64'hEEEE;
        busy_set_en = 1'b1; busy_set_addr = 5'd0;
        tick();
        idle();
        rs1_en = 1'b1; rs1_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL x0_write: data=%h busy=%b expected 0/0", rs1_data, rs1_busy);
        end
        $display("x0 write: read %h busy %b", rs1_data, rs1_busy);
    endtask

    task automatic test_busy();
        rs2_en = 1'b1; rs2_addr = 5'd7;
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b1) begin
            errors++; $display("FAIL busy_cycle1: rs2_busy=%b expected 1", rs2_busy);
        end
        tick();
        checks++;
        if (rs2_busy !== 1'b1) begin
            errors++; $display("FAIL busy_cycle2: rs2_busy=%b expected 1", rs2_busy);
        end
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'hAB;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b0 || rs2_data !== 64'hAB) begin
            errors++; $display("FAIL busy_cleared: busy=%b data=%h expected 0/ab", rs2_busy, rs2_data);
        end
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'hCD;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_busy !== 1'b1 || rs2_data !== 64'hCD) begin
            errors++; $display("FAIL busy_set_wins: busy=%b data=%h expected 1/cd", rs2_busy, rs2_data);
        end
        $display("busy x7: final busy %b data %h", rs2_busy, rs2_data);
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_data;
        logic            exp_busy;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h33;
        tick();
        idle();
        busy_set_en = 1'b1; busy_set_addr = 5'd3;
        tick();
        idle();
        rs1_en = 1'b1; rs1_addr = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h44;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 64'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_data = 64'h55; exp_busy = 1'b0;
`else
        exp_data = 64'h33; exp_busy = 1'b1;
`endif
        checks++;
        if (rs1_data !== exp_data || rs1_busy !== exp_busy) begin
            errors++; $display("FAIL bypass_same_cycle: data=%h busy=%b expected %h/%b",
                               rs1_data, rs1_busy, exp_data, exp_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 64'h55 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL bypass_next_cycle: data=%h busy=%b expected 55/0", rs1_data, rs1_busy);
        end
        $display("write-read x3: next-cycle data %h", rs1_data);
    endtask

    task automatic test_en_gate();
        busy_set_en = 1'b1; busy_set_addr = 5'd5;
        tick();
        idle();
        rs1_en = 1'b0; rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== '0 || rs1_busy !== 1'b0) begin
            errors++; $display("FAIL en_low: data=%h busy=%b expected 0/0", rs1_data, rs1_busy);
        end
        rs1_en = 1'b1;
        #1;
        checks++;
        if (rs1_data !== 64'h2222 || rs1_busy !== 1'b1) begin
            errors++; $display("FAIL en_high: data=%h busy=%b expected 2222/1", rs1_data, rs1_busy);
        end
        $display("enable gate x5: data %h busy %b", rs1_data, rs1_busy);
    endtask

    task automatic test_midsweep_reset();
        logic exp_ready;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h99;
        tick();
        idle();
        rs1_en = 1'b1; rs1_addr = 5'd9;
        #1;
        checks++;
        if (rs1_data !== 64'h99) begin
            errors++; $display("FAIL pre_reset_x9: data=%h expected 99", rs1_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (ready !== 1'b0) begin
                errors++; $display("FAIL first_sweep_ready[%0d]: ready=%b expected 0", k, ready);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL midsweep_rst_ready: ready=%b expected 0", ready);
        end
        for (int k = 0; k < NREG; k++) begin
            if (k == 25) begin
                wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 64'hBEEF;
                busy_set_en = 1'b1; busy_set_addr = 5'd4;
            end
            tick();
            idle();
            exp_ready = (k == NREG - 1);
            checks++;
            if (ready !== exp_ready) begin
                errors++; $display("FAIL restart_ready[%0d]: ready=%b expected %b", k, ready, exp_ready);
            end
        end
        rs1_en = 1'b1; rs1_addr = 5'd9;
        rs2_en = 1'b1; rs2_addr = 5'd2;
        #1;
        checks++;
        if (rs1_data !== '0 || rs2_data !== '0) begin
            errors++; $display("FAIL restart_data: x9=%h x2=%h expected 0/0", rs1_data, rs2_data);
        end
        rs1_addr = 5'd7; rs2_addr = 5'd4;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++; $display("FAIL restart_busy: x7=%b x4=%b expected 0/0", rs1_busy, rs2_busy);
        end
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_data !== '0) begin
            errors++; $display("FAIL restart_x5: busy=%b data=%h expected 0/0", rs1_busy, rs1_data);
        end
        $display("mid-sweep reset: ready %b, x9 %h", ready, rs1_data);
    endtask

    initial begin
        rst = 1'b1;
        rs1_en = 1'b0; rs1_addr = '0;
        rs2_en = 1'b0; rs2_addr = '0;
        idle();
        test_reset();
        test_dual_write();
        test_x0();
        test_busy();
        test_bypass();
        test_en_gate();
        test_midsweep_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of two, >= 4).
REQ-003 SHALL have derived parameter AW = log2(NREG), address width.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rs1_en / rs2_en  input  1  read-port enable.
REQ-008 rs1_addr / rs2_addr  input  AW  read addresses.
REQ-009 rs1_data / rs2_data  output  XLEN  read data, combinational.
REQ-010 rs1_busy / rs2_busy  output  1  scoreboard busy bit of the addressed register.
REQ-011 wr0_en / wr1_en  input  1  write-port enables; wr1 is the higher-priority port.
REQ-012 wr0_addr / wr1_addr  input  AW  write addresses.
REQ-013 wr0_data / wr1_data  input  XLEN  write data.
REQ-014 busy_set_en  input  1  mark a register as pending (producer issued).
REQ-015 busy_set_addr  input  AW  register to mark pending.
REQ-016 ready  output  1  high when the array is initialised and accepting traffic.

Function
REQ-017 SHALL implement FSM states INIT and RUN; INIT clears one entry per cycle using a sweep counter running 0..NREG-1.
REQ-018 SHALL enter RUN on the edge after the counter reaches NREG-1; ready rises exactly NREG cycles after rst deasserts.
REQ-019 In INIT: writes and busy_set are ignored; rs*_data = 0; rs*_busy = 0.
REQ-020 rsN_data SHALL be 0 when rsN_en=0, rsN_addr=0, or ready=0; otherwise the stored entry.
REQ-021 A write SHALL update the entry at posedge when wrN_en=1, wrN_addr!=0, and state=RUN.
REQ-022 Writes with address 0 SHALL be discarded; entry 0 reads as 0 at all times.
REQ-023 When both write ports target the same nonzero address in one cycle, wr1_data SHALL be stored.
REQ-024 A write to address A SHALL clear busy[A] on the same edge.
REQ-025 busy_set_en=1 SHALL set busy[busy_set_addr] at posedge; address 0 is ignored; busy[0] is constant 0.
REQ-026 A simultaneous set and clear of the same address SHALL leave busy=1 (new producer wins).
REQ-027 rsN_busy SHALL show the registered busy bit; it is 0 when rsN_en=0.

Reset
REQ-028 rst=1 at any posedge SHALL force INIT, reset the sweep counter to 0, clear all busy bits, and drive ready=0 on the following cycle.
REQ-029 rst asserted mid-sweep or during RUN SHALL restart the full sweep; no partial state survives.
REQ-030 Sweep writes SHALL take precedence over port writes; the array has no other reset path.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL enable same-cycle write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN: a read of a nonzero address being written this cycle returns the write data, with wr1 taking priority over wr0, and rsN_busy reads 0 unless busy_set also targets that address.
REQ-033 Without REGFILE_BYPASS_EN: reads return the value held before the edge, and busy reflects the registered state only.

Verification
REQ-034 Deassert rst at cycle 0 -> ready=0 for cycles 0..31, ready=1 at cycle 32 (NREG=32); every register reads 0.
REQ-035 RUN; wr0 x5<=0x1111, wr1 x5<=0x2222 in the same cycle -> next cycle rs1_addr=5 reads 0x2222.
REQ-036 Write x0<=0xFFFF -> rs1_addr=0 reads 0; rs1_busy=0.
REQ-037 busy_set x7, then wr0 x7<=0xAB two cycles later -> rs2_busy=1 for 2 cycles, then 0; set and write of x7 in the same cycle -> busy stays 1.
REQ-038 With REGFILE_BYPASS_EN, wr1 x3<=0x55 while rs1_addr=3 -> rs1_data=0x55 in that cycle; without the macro -> the old value, 0x55 on the next cycle.
REQ-039 Assert rst at sweep index 10 -> ready stays 0, the sweep restarts at 0, and a prior write to x9 reads 0 after ready rises.
